// File: rtl/dtlb_pkg.sv
// rtl/dtlb_pkg.sv - shared data TLB definitions: PTE layout and refill walker states
package dtlb_pkg;

  localparam int PTE_WIDTH        = 16;
  localparam int PTE_VALID_BIT    = 15;
  localparam int PTE_PPN_LSB      = 0;
  localparam int PAGE_OFFSET_BITS = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    FILL  = 2'd2,
    FAULT = 2'd3
  } walk_state_t;

  function automatic logic pte_valid(input logic [PTE_WIDTH-1:0] pte);
    return pte[PTE_VALID_BIT];
  endfunction

endpackage

// File: rtl/dtlb_miss_handler_round_robin_ptr.sv
// rtl/dtlb_miss_handler_round_robin_ptr.sv - modulo-NUM_LINES victim counter with reset value
module round_robin_ptr #(
  parameter int NUM_LINES   = 4,
  parameter int RESET_VALUE = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  output logic [$clog2(NUM_LINES)-1:0] value
);

  localparam int IDX_W = $clog2(NUM_LINES);

  // NUM_LINES is a power of two, so the natural binary wrap is the modulo.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= IDX_W'(RESET_VALUE);
    end else if (enable) begin
      value <= value + IDX_W'(1);
    end
  end

endmodule

// File: rtl/dtlb_miss_handler.sv
// rtl/dtlb_miss_handler.sv - data TLB refill engine: one-level PTE walk, fill or page fault
module dtlb_miss_handler
  import dtlb_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    VPN_WIDTH    = 9,
  parameter int                    NUM_LINES    = 4,
  parameter logic [ADDR_WIDTH-1:0] PT_BASE      = 16'h1000,
  parameter int                    VICTIM_RESET = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         lookup_valid,
  input  logic                         is_hit,
  input  logic [VPN_WIDTH-1:0]         offending_vpn,
  output logic                         stall,
  output logic                         mem_req,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic                         mem_ack,
  input  logic [PTE_WIDTH-1:0]         mem_rdata,
  output logic                         fill_valid,
  output logic [$clog2(NUM_LINES)-1:0] fill_index,
  output logic [VPN_WIDTH-1:0]         fill_vpn,
  output logic [VPN_WIDTH-1:0]         fill_ppn,
  output logic                         page_fault,
  output logic [VPN_WIDTH-1:0]         fault_vpn,
  input  logic                         fault_ack
);

  localparam int IDX_W = $clog2(NUM_LINES);

  walk_state_t          state;
  logic [VPN_WIDTH-1:0] vpn_q;
  logic [IDX_W-1:0]     victim;
  logic                 unused_pte_bits;

  assign unused_pte_bits = ^mem_rdata[PTE_VALID_BIT-1:VPN_WIDTH];

  round_robin_ptr #(
    .NUM_LINES  (NUM_LINES),
    .RESET_VALUE(VICTIM_RESET)
  ) u_victim (
    .clk   (clk),
    .reset (reset),
    .enable(state == FILL),
    .value (victim)
  );

  // Combinational so the memory stage freezes in the very cycle the miss shows up.
  assign stall = (state != IDLE) | (lookup_valid & ~is_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      vpn_q      <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      fill_valid <= 1'b0;
      fill_index <= '0;
      fill_vpn   <= '0;
      fill_ppn   <= '0;
      page_fault <= 1'b0;
      fault_vpn  <= '0;
    end else begin
      fill_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (lookup_valid && !is_hit) begin
            vpn_q    <= offending_vpn;
            mem_addr <= PT_BASE + ADDR_WIDTH'({offending_vpn, 1'b0});
            mem_req  <= 1'b1;
            state    <= WALK;
          end
        end
        WALK: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (pte_valid(mem_rdata)) begin
              fill_valid <= 1'b1;
              fill_index <= victim;
              fill_vpn   <= vpn_q;
              fill_ppn   <= mem_rdata[PTE_PPN_LSB +: VPN_WIDTH];
              state      <= FILL;
            end else begin
              page_fault <= 1'b1;
              fault_vpn  <= vpn_q;
              state      <= FAULT;
            end
          end
        end
        FILL: state <= IDLE;
        FAULT: begin
          if (fault_ack) begin
            page_fault <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtlb_miss_handler.sv
// tb/tb_dtlb_miss_handler.sv - scoreboard bench for the data TLB refill engine
module tb_dtlb_miss_handler;

  typedef struct {
    logic [1:0] index;
    logic [8:0] vpn;
    logic [8:0] ppn;
  } fill_t;

  logic        clk;
  logic        reset;
  logic        lookup_valid;
  logic        is_hit;
  logic [8:0]  offending_vpn;
  logic        stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        fill_valid;
  logic [1:0]  fill_index;
  logic [8:0]  fill_vpn;
  logic [8:0]  fill_ppn;
  logic        page_fault;
  logic [8:0]  fault_vpn;
  logic        fault_ack;

  logic        hi_stall;
  logic        hi_mem_req;
  logic [15:0] hi_mem_addr;
  logic        hi_fill_valid;
  logic [1:0]  hi_fill_index;
  logic [8:0]  hi_fill_vpn;
  logic [8:0]  hi_fill_ppn;
  logic        hi_page_fault;
  logic [8:0]  hi_fault_vpn;

  int          vectors;
  int          miscompares;
  logic [1:0]  exp_victim;
  fill_t       sb[$];

  dtlb_miss_handler dut (
    .clk          (clk),
    .reset        (reset),
    .lookup_valid (lookup_valid),
    .is_hit       (is_hit),
    .offending_vpn(offending_vpn),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .fill_valid   (fill_valid),
    .fill_index   (fill_index),
    .fill_vpn     (fill_vpn),
    .fill_ppn     (fill_ppn),
    .page_fault   (page_fault),
    .fault_vpn    (fault_vpn),
    .fault_ack    (fault_ack)
  );

  // Second instance with a page table near the top of memory for the address wrap.
  dtlb_miss_handler #(.PT_BASE(16'hFE00)) dut_hi (
    .clk          (clk),
    .reset        (reset),
    .lookup_valid (lookup_valid),
    .is_hit       (is_hit),
    .offending_vpn(offending_vpn),
    .stall        (hi_stall),
    .mem_req      (hi_mem_req),
    .mem_addr     (hi_mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .fill_valid   (hi_fill_valid),
    .fill_index   (hi_fill_index),
    .fill_vpn     (hi_fill_vpn),
    .fill_ppn     (hi_fill_ppn),
    .page_fault   (hi_page_fault),
    .fault_vpn    (hi_fault_vpn),
    .fault_ack    (fault_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Miss at the current cycle, ack after walk_cycles WALK cycles; ends in M+2 (fill) or M+1 (fault).
  task automatic run_miss(input logic [8:0] vpn, input logic [15:0] pte, input int walk_cycles,
                          output logic [1:0] got_index);
    int          stall_cycles;
    fill_t       exp;
    logic [15:0] exp_addr;
    exp_addr     = 16'h1000 + {6'd0, vpn, 1'b0};
    stall_cycles = 0;
    got_index    = 2'bxx;
    lookup_valid  = 1'b1;
    is_hit        = 1'b0;
    offending_vpn = vpn;
    #1;
    if (stall === 1'b1) stall_cycles++;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL miss_stall_same_cycle vpn=%h got %b want 1", vpn, stall);
    end
    for (int k = 1; k <= walk_cycles; k++) begin
      step;
      lookup_valid = 1'b0;
      if (stall === 1'b1) stall_cycles++;
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin
        miscompares++;
        $display("FAIL walk_req vpn=%h cyc=%0d got req=%b addr=%h want req=1 addr=%h",
                 vpn, k, mem_req, mem_addr, exp_addr);
      end
      if (k == walk_cycles) begin
        mem_ack   = 1'b1;
        mem_rdata = pte;
        if (pte[15]) begin
          exp.index = exp_victim;
          exp.vpn   = vpn;
          exp.ppn   = pte[8:0];
          sb.push_back(exp);
          exp_victim = exp_victim + 2'd1;
        end
      end
    end
    step;
    mem_ack = 1'b0;
    if (stall === 1'b1) stall_cycles++;
    if (pte[15]) begin
      got_index = fill_index;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL fill_scoreboard_empty vpn=%h", vpn);
      end else begin
        exp = sb.pop_front();
        if (fill_valid !== 1'b1 || fill_index !== exp.index || fill_vpn !== exp.vpn ||
            fill_ppn !== exp.ppn) begin
          miscompares++;
          $display("FAIL fill vpn=%h got v=%b idx=%0d vpn=%h ppn=%h want v=1 idx=%0d vpn=%h ppn=%h",
                   vpn, fill_valid, fill_index, fill_vpn, fill_ppn, exp.index, exp.vpn, exp.ppn);
        end
      end
      step;
      vectors++;
      if (stall !== 1'b0 || fill_valid !== 1'b0 || mem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL replay_idle vpn=%h got stall=%b fill=%b req=%b want 0 0 0",
                 vpn, stall, fill_valid, mem_req);
      end
      vectors++;
      if (stall_cycles != walk_cycles + 2) begin
        miscompares++;
        $display("FAIL stall_length vpn=%h got %0d want %0d", vpn, stall_cycles, walk_cycles + 2);
      end
    end else begin
      vectors++;
      if (page_fault !== 1'b1 || fault_vpn !== vpn || fill_valid !== 1'b0 || stall !== 1'b1) begin
        miscompares++;
        $display("FAIL fault_raise got pf=%b fvpn=%h fill=%b stall=%b want 1 %h 0 1",
                 page_fault, fault_vpn, fill_valid, stall, vpn);
      end
    end
  endtask

  task automatic test_reset;
    vectors++;
    if (stall !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 16'h0 || fill_valid !== 1'b0 ||
        fill_index !== 2'd0 || fill_vpn !== 9'h0 || fill_ppn !== 9'h0 || page_fault !== 1'b0 ||
        fault_vpn !== 9'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got stall=%b req=%b addr=%h fv=%b idx=%0d fvpn=%h fppn=%h pf=%b fltvpn=%h want all 0",
               stall, mem_req, mem_addr, fill_valid, fill_index, fill_vpn, fill_ppn, page_fault, fault_vpn);
    end
  endtask

  task automatic test_valid_fill;
    logic [1:0] idx;
    run_miss(9'h020, 16'h8005, 2, idx);
    vectors++;
    if (idx !== 2'd2) begin
      miscompares++;
      $display("FAIL first_fill_index got %0d want 2", idx);
    end
  endtask

  task automatic test_fault;
    logic [1:0] idx;
    run_miss(9'h033, 16'h0005, 1, idx);
    for (int i = 0; i < 5; i++) begin
      step;
      vectors++;
      if (page_fault !== 1'b1 || stall !== 1'b1 || fill_valid !== 1'b0 || fault_vpn !== 9'h033) begin
        miscompares++;
        $display("FAIL fault_hold cyc=%0d got pf=%b stall=%b fill=%b fvpn=%h want 1 1 0 033",
                 i, page_fault, stall, fill_valid, fault_vpn);
      end
    end
    fault_ack = 1'b1;
    step;
    fault_ack = 1'b0;
    vectors++;
    if (page_fault !== 1'b0 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_ack_idle got pf=%b stall=%b want 0 0", page_fault, stall);
    end
    run_miss(9'h034, 16'h8011, 1, idx);
    vectors++;
    if (idx !== 2'd3) begin
      miscompares++;
      $display("FAIL victim_after_fault got %0d want 3", idx);
    end
  endtask

  task automatic test_reset_mid_walk;
    lookup_valid  = 1'b1;
    is_hit        = 1'b0;
    offending_vpn = 9'h044;
    step;
    lookup_valid = 1'b0;
    step;
    reset = 1'b1;
    step;
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'h8007;
    exp_victim = 2'd2;
    test_reset;
    step;
    mem_ack = 1'b0;
    vectors++;
    if (fill_valid !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b0 || page_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL late_ack_ignored got fill=%b req=%b stall=%b pf=%b want 0 0 0 0",
               fill_valid, mem_req, stall, page_fault);
    end
  endtask

  task automatic test_wrap;
    logic [1:0] idx;
    logic [1:0] want[4];
    want = '{2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 4; i++) begin
      run_miss(9'h100 + 9'(i), 16'h8000 | 16'(8'h40 + i), 1, idx);
      vectors++;
      if (idx !== want[i]) begin
        miscompares++;
        $display("FAIL wrap_index miss=%0d got %0d want %0d", i, idx, want[i]);
      end
    end
  endtask

  task automatic test_hit_traffic;
    lookup_valid  = 1'b1;
    is_hit        = 1'b1;
    offending_vpn = 9'h055;
    for (int i = 0; i < 20; i++) begin
      mem_ack   = (i == 10);
      mem_rdata = 16'h8003;
      fault_ack = (i == 5);
      step;
      vectors++;
      if (stall !== 1'b0 || mem_req !== 1'b0 || fill_valid !== 1'b0 || page_fault !== 1'b0) begin
        miscompares++;
        $display("FAIL hit_traffic cyc=%0d got stall=%b req=%b fill=%b pf=%b want 0 0 0 0",
                 i, stall, mem_req, fill_valid, page_fault);
      end
    end
    mem_ack      = 1'b0;
    fault_ack    = 1'b0;
    lookup_valid = 1'b0;
    is_hit       = 1'b0;
    step;
  endtask

  task automatic test_addr_wrap;
    lookup_valid  = 1'b1;
    is_hit        = 1'b0;
    offending_vpn = 9'h1FF;
    step;
    lookup_valid = 1'b0;
    vectors++;
    if (hi_mem_req !== 1'b1 || hi_mem_addr !== 16'h01FE) begin
      miscompares++;
      $display("FAIL addr_wrap got req=%b addr=%h want 1 01fe", hi_mem_req, hi_mem_addr);
    end
    vectors++;
    if (mem_addr !== 16'h13FE) begin
      miscompares++;
      $display("FAIL addr_top_vpn got %h want 13fe", mem_addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = 16'h8001;
    step;
    mem_ack = 1'b0;
    step;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    exp_victim    = 2'd2;
    reset         = 1'b1;
    lookup_valid  = 1'b0;
    is_hit        = 1'b0;
    offending_vpn = 9'h0;
    mem_ack       = 1'b0;
    mem_rdata     = 16'h0;
    fault_ack     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset;
    test_valid_fill;
    test_fault;
    test_reset_mid_walk;
    test_wrap;
    test_hit_traffic;
    test_addr_wrap;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/dtlb_miss_handler.md
# dtlb_miss_handler

Hardware refill engine directly downstream of the data TLB. On a TLB miss it stalls the memory stage, captures the offending virtual page number, and reads one page-table entry from memory. On a valid entry it issues a single-cycle fill write into a round-robin-selected TLB line; on an invalid entry it raises a page fault. It supplies the TLB write port that the data TLB currently lacks.

## Interface
- `ADDR_WIDTH`, 16, byte address width.
- `VPN_WIDTH`, 9, page number width (ADDR_WIDTH-7; 128 B pages).
- `NUM_LINES`, 4, TLB lines; must be a power of two.
- `PT_BASE`, 16'h1000, byte address of the page table; one 16-bit PTE per VPN.
- `VICTIM_RESET`, 2, victim pointer value after reset; lines 0–1 hold boot mappings.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high; clock `clk`.
- `lookup_valid` in 1: memory stage performs a TLB lookup this cycle.
- `is_hit` in 1: TLB hit, covering both addresses for word accesses.
- `offending_vpn` in VPN_WIDTH: virtual page number that missed.
- `stall` out 1: freezes the memory stage.
- `mem_req` out 1: page-table read request.
- `mem_addr` out ADDR_WIDTH: PTE byte address.
- `mem_ack` in 1: read complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 16: PTE. Bit 15 is valid; bits [VPN_WIDTH-1:0] are the PPN; other bits are ignored.
- `fill_valid` out 1: write one TLB line this cycle.
- `fill_index` out log2(NUM_LINES): line to write.
- `fill_vpn` out VPN_WIDTH: virtual tag for the line.
- `fill_ppn` out VPN_WIDTH: physical tag for the line.
- `page_fault` out 1: level-held fault request.
- `fault_vpn` out VPN_WIDTH: faulting page number.
- `fault_ack` in 1: exception unit has taken the fault.

## Operation
- States are IDLE, WALK, FILL and FAULT.
- IDLE → WALK when `lookup_valid & !is_hit`. In that cycle `offending_vpn` is captured into `vpn_q`.
- WALK:
  - `mem_req`=1 and `mem_addr` = PT_BASE + {vpn_q,1'b0}, computed modulo 2^ADDR_WIDTH.
  - `mem_req` is held until `mem_ack`; `mem_addr` is stable while `mem_req` is high.
  - On `mem_ack`, if `mem_rdata[15]`=1 the PPN is captured and the state goes to FILL.
  - Otherwise the state goes to FAULT.
- FILL:
  - `fill_valid`=1 for exactly one cycle, with `fill_index`=victim, `fill_vpn`=vpn_q and `fill_ppn` = captured PPN.
  - victim ← victim+1, wrapping from NUM_LINES-1 to 0.
  - Next state is IDLE.
- FAULT:
  - `page_fault`=1 and `fault_vpn`=vpn_q.
  - Held until `fault_ack`, then the state goes to IDLE. The victim pointer does not change.
- `stall` = (state≠IDLE) | (state==IDLE & lookup_valid & !is_hit). It is combinational, so a miss stalls in the same cycle it occurs.
- Lookups and misses outside IDLE are ignored; the stage is frozen.
- A `mem_ack` outside WALK is ignored.
- A `fault_ack` outside FAULT is ignored.
- The handler never fills the same VPN twice per miss. The replay after FILL hits.

## Timing
- All outputs after reset: `stall`=0 (given no miss input), `mem_req`=0, `mem_addr`=0, `fill_valid`=0, `fill_index`=0, `fill_vpn`=0, `fill_ppn`=0, `page_fault`=0, `fault_vpn`=0.
- Internal reset values: victim=VICTIM_RESET, state=IDLE.
- Miss in cycle N: `mem_req` rises in N+1.
- `mem_ack` in cycle M (M≥N+1, so an ack in the first WALK cycle is legal):
  - cycle M+1: `fill_valid` is high;
  - cycle M+2: IDLE with `stall`=0 and the lookup replays.
- Best-case miss penalty is 3 stall cycles (N, N+1, N+2).
- Fault path: `page_fault` rises in M+1. With `fault_ack` in cycle K, the state is IDLE in K+1.
- Reset mid-walk or mid-fault: the state returns to IDLE on the next edge and `mem_req`/`page_fault` drop. An in-flight ack arriving after that is ignored.
- `reset` and `mem_ack` in the same cycle: reset wins and no fill occurs.

## Structure
- Shared package `dtlb_pkg`: PTE_VALID_BIT (15), PAGE_OFFSET_BITS (7), the state enum, and the PTE field extraction constants. The data TLB and this block share it.
- One natural sub-module: `round_robin_ptr`, a modulo-NUM_LINES counter with reset value, enable, and current-value output.
- The FSM and datapath registers stay in the top module.

## Test plan
- Miss on vpn 9'h020 with PTE `mem_rdata`=16'h8005 and ack after 2 WALK cycles:
  - `mem_addr`=16'h1040 held during WALK;
  - then one `fill_valid` with index 2, vpn 9'h020, ppn 9'h005;
  - `stall` high for exactly 4 cycles.
- Four consecutive valid misses: `fill_index` sequence is 2, 3, 0, 1 (wrap check).
- Miss with `mem_rdata`=16'h0005:
  - `page_fault`=1, `fault_vpn` correct, `stall` held, no `fill_valid`;
  - `fault_ack` after 5 cycles → IDLE next cycle, victim unchanged.
- Reset asserted in the 2nd WALK cycle, `mem_ack` in the following cycle: no `fill_valid`, outputs at their reset values, victim=2.
- Hit traffic (`lookup_valid`=1, `is_hit`=1) for 20 cycles: `stall`, `mem_req` and `fill_valid` stay at 0. A `mem_ack` pulse in IDLE is ignored.
- vpn 9'h1FF with PT_BASE=16'hFE00: `mem_addr`=16'h01FE (wrap-around).
